ps2_host_tx: RTL

// - Host-to-device PS/2 transmitter; the sending half of the PS/2 link whose receive half is ps2_keyboard.
// - Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard and reports the device acknowledge.
// - Drives both PS/2 lines open-drain through *_oe outputs; the top level builds the tristate.
// - busy lets the receiver ignore clock activity during a host frame.

---
 rtl/ps2_host_tx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED
// set-LEDs or 0xFF reset) to the attached keyboard and reports whether the
// device acknowledged it. Both PS/2 lines are driven open-drain through *_oe
// enables; the top level builds the actual tristate buffers.
//
// Frame sequence: inhibit (clock held low), request-to-send (data low, clock
// released), then the device clocks out start, d0..d7, parity (odd), stop and
// finally drives its own acknowledge bit. A timeout watchdog covers the whole
// device-clocked part of the frame.
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   tx_data      in   [7:0] command byte, sampled on acceptance
//   tx_valid     in   request; byte accepted when tx_valid && tx_ready
//   tx_ready     out  high only while idle
//   busy         out  high in every state except idle
//   ps2_clk      in   PS/2 clock line level (asynchronous)
//   ps2_data     in   PS/2 data line level (asynchronous)
//   ps2_clk_oe   out  1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  out  1 = pull PS/2 data low, 0 = release
//   done         out  one-cycle pulse at the end of every accepted frame
//   ack_ok       out  valid with done: device drove the ack bit low
//   err          out  valid with done: the frame timed out
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,   // clk cycles the clock is held low
    parameter int TIMEOUT_CYCLES = 750000  // clk cycles from SEND entry to abort
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_REL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Line synchronizers plus one history stage for edge detection.
    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;

    logic [8:0]    frame;     // {parity, d7..d0}
    logic [3:0]    bit_cnt;   // device falling edges seen in SEND
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          armed;     // clock line seen high since SEND entry
    logic          ack_pend;  // ack level captured on the 11th falling edge

    logic fe, fe_q, last_fe, inh_end, to_hit, cur_bit, enter_done;

    assign fe      = clk_prev & ~clk_s2;
    // The falling edge caused by our own inhibit can still be in the
    // synchronizer when SEND starts; only count edges once the released line
    // has been seen high.
    assign fe_q    = fe & armed;
    assign last_fe = fe_q && (bit_cnt == 4'd10);
    assign inh_end = (inh_cnt == INH_LAST);
    assign to_hit  = (to_cnt == TO_LAST);

    // Bit currently presented: start(0), d0..d7, parity, then stop(1).
    always_comb begin
        cur_bit = 1'b1;
        if (bit_cnt == 4'd0)
            cur_bit = 1'b0;
        else if (bit_cnt <= 4'd9)
            cur_bit = frame[bit_cnt - 4'd1];
    end

    // NOTE: every output and next-state value gets a default before the case
    // so no path leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_nxt   = state;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid)
                    state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_end)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_nxt   = S_SEND;
            end
            S_SEND: begin
                ps2_data_oe = ~cur_bit;
                // Timeout has priority over a coincident 11th edge.
                if (to_hit)
                    state_nxt = S_DONE;
                else if (last_fe)
                    state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (to_hit || (clk_s2 && data_s2))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            frame    <= '0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            armed    <= 1'b0;
            ack_pend <= 1'b0;
            ack_ok   <= 1'b0;
            err      <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;

            case (state)
                S_IDLE: begin
                    inh_cnt <= '0;
                    if (tx_valid) begin
                        frame  <= {~^tx_data, tx_data};
                        ack_ok <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                S_INHIBIT: inh_cnt <= inh_cnt + 1'b1;
                S_REQ: begin
                    bit_cnt  <= '0;
                    to_cnt   <= '0;
                    armed    <= 1'b0;
                    ack_pend <= 1'b0;
                end
                S_SEND: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (clk_s2)
                        armed <= 1'b1;
                    if (fe_q)
                        bit_cnt <= bit_cnt + 4'd1;
                    if (last_fe)
                        ack_pend <= ~data_s2;
                end
                S_WAIT_REL: to_cnt <= to_cnt + 1'b1;
                default: ;
            endcase

            // Result flags only move on the way into DONE.
            if (enter_done) begin
                err    <= to_hit;
                ack_ok <= ~to_hit & ack_pend;
            end
        end
    end

endmodule
